// File: rtl/instruction_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: widths, reset PC,
// the bubble instruction word and the IF/ID field bundle.
package instruction_fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.instruction = NOP_WORD;
    b.pc_plus4    = '0;
    b.valid       = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_ifid_pipe_reg.sv
// IF/ID pipeline register: synchronous reset and squash both load a bubble,
// hold freezes the contents, otherwise the fetched bundle is captured.
module ifid_pipe_reg
  import instruction_fetch_stage_pkg::*;
(
  input  logic  clk_i,
  input  logic  srst_i,
  input  logic  hold_i,
  input  logic  squash_i,
  input  ifid_t load_i,
  output ifid_t q_o
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (!hold_i) begin
      if (squash_i) ifid_d = ifid_bubble();
      else          ifid_d = load_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) ifid_q <= ifid_bubble();
    else        ifid_q <= ifid_d;
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, instruction-memory address, IF/ID register and
// valid-fetch counter. Define BRANCH_DELAY_SLOT_EN to keep the delay-slot word on redirect.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
)
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] Fetch_Count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic        squash;
  ifid_t       fetch_bundle;
  ifid_t       ifid;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef BRANCH_DELAY_SLOT_EN
  assign squash = 1'b0;
`else
  assign squash = Redirect;
`endif

  // Stall outranks Redirect; decode re-asserts the redirect once the stall clears.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (!Stall) begin
      if (Redirect) pc_d = {Redirect_Target[31:2], 2'b00};
      else          pc_d = pc_plus4;
      if (!squash)  count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= PC_RESET;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign fetch_bundle.instruction = Imem_Data;
  assign fetch_bundle.pc_plus4    = pc_plus4;
  assign fetch_bundle.valid       = 1'b1;

  ifid_pipe_reg u_ifid (
    .clk_i    (Clk),
    .srst_i   (Rst),
    .hold_i   (Stall),
    .squash_i (squash),
    .load_i   (fetch_bundle),
    .q_o      (ifid)
  );

  assign Imem_Addr        = pc_q;
  assign IFID_Instruction = ifid.instruction;
  assign IFID_PCPlus4     = ifid.pc_plus4;
  assign IFID_Valid       = ifid.valid;
  assign Fetch_Count      = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus a randomized run
// against a reference model, on a default-reset instance and a wrap-around instance.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redir;
  logic [31:0] tgt;
  logic [31:0] addr [2];
  logic [31:0] data [2];
  logic [31:0] instr [2];
  logic [31:0] pc4 [2];
  logic        valid [2];
  logic [31:0] cnt [2];

  int checks = 0;
  int passed = 0;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  always #5 clk = ~clk;

  // Instruction memory: word at address a is a + 0x1000.
  assign data[0] = addr[0] + 32'h1000;
  assign data[1] = addr[1] + 32'h1000;

  instruction_fetch_stage #(.PC_RESET(RST_A)) dut_a (
    .Clk(clk), .Rst(rst), .Stall(stall), .Redirect(redir), .Redirect_Target(tgt),
    .Imem_Addr(addr[0]), .Imem_Data(data[0]), .IFID_Instruction(instr[0]),
    .IFID_PCPlus4(pc4[0]), .IFID_Valid(valid[0]), .Fetch_Count(cnt[0]));

  instruction_fetch_stage #(.PC_RESET(RST_B)) dut_b (
    .Clk(clk), .Rst(rst), .Stall(stall), .Redirect(redir), .Redirect_Target(tgt),
    .Imem_Addr(addr[1]), .Imem_Data(data[1]), .IFID_Instruction(instr[1]),
    .IFID_PCPlus4(pc4[1]), .IFID_Valid(valid[1]), .Fetch_Count(cnt[1]));

  // Reference model state, one slot per instance
  logic [31:0] m_pc [2];
  logic [31:0] m_ins [2];
  logic [31:0] m_p4 [2];
  logic        m_v [2];
  logic [31:0] m_cnt [2];

  task automatic model_step(input int k);
    logic [31:0] rv;
    rv = (k == 0) ? RST_A : RST_B;
    if (rst) begin
      m_pc[k] = rv; m_ins[k] = 32'h0; m_p4[k] = 32'h0; m_v[k] = 1'b0; m_cnt[k] = 32'h0;
    end else if (!stall) begin
      if (redir && !DS) begin
        m_ins[k] = 32'h0; m_p4[k] = 32'h0; m_v[k] = 1'b0;
      end else begin
        m_ins[k] = m_pc[k] + 32'h1000; m_p4[k] = m_pc[k] + 32'd4; m_v[k] = 1'b1;
        m_cnt[k] = m_cnt[k] + 32'd1;
      end
      m_pc[k] = redir ? (tgt & 32'hFFFF_FFFC) : (m_pc[k] + 32'd4);
    end
  endtask

  // One clock edge; inputs are stable, outputs sampled 1 time unit after the edge.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic s, input logic d, input logic [31:0] t);
    rst = r; stall = s; redir = d; tgt = t;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checks++;
    if ({addr[0], instr[0], pc4[0], valid[0], cnt[0]} !== {RST_A, 32'h0, 32'h0, 1'b0, 32'h0})
      $display("FAIL reset_state: addr=%h ins=%h pc4=%h v=%b cnt=%0d, want %h 0 0 0 0",
               addr[0], instr[0], pc4[0], valid[0], cnt[0], RST_A);
    else passed++;
    rst = 1'b0;
    tick();
    checks++;
    if ({instr[0], pc4[0], valid[0], cnt[0], addr[0]} !== {32'h1000, 32'h4, 1'b1, 32'd1, 32'h4})
      $display("FAIL first_fetch: ins=%h pc4=%h v=%b cnt=%0d addr=%h, want 1000 4 1 1 4",
               instr[0], pc4[0], valid[0], cnt[0], addr[0]);
    else passed++;
    tick();
    checks++;
    if (addr[0] !== 32'h8) $display("FAIL second_pc: addr=%h want 8", addr[0]);
    else passed++;
    $display("test_reset done");
  endtask

  task automatic test_stall();
    do_reset();
    run(4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({addr[0], instr[0], pc4[0], valid[0], cnt[0]} !== {32'h10, 32'h100C, 32'h10, 1'b1, 32'd4})
        $display("FAIL stall_hold%0d: addr=%h ins=%h pc4=%h v=%b cnt=%0d, want 10 100c 10 1 4",
                 i, addr[0], instr[0], pc4[0], valid[0], cnt[0]);
      else passed++;
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({addr[0], instr[0], cnt[0]} !== {32'h14, 32'h1010, 32'd5})
      $display("FAIL stall_resume: addr=%h ins=%h cnt=%0d, want 14 1010 5", addr[0], instr[0], cnt[0]);
    else passed++;
    $display("test_stall done");
  endtask

  task automatic test_redirect();
    logic [31:0] e_ins, e_p4, e_cnt;
    logic        e_v;
    do_reset();
    run(8);
    set_in(1'b0, 1'b0, 1'b1, 32'h40);
    tick();
    e_ins = DS ? 32'h1020 : 32'h0;
    e_p4  = DS ? 32'h24 : 32'h0;
    e_v   = DS;
    e_cnt = DS ? 32'd9 : 32'd8;
    checks++;
    if ({addr[0], instr[0], pc4[0], valid[0], cnt[0]} !== {32'h40, e_ins, e_p4, e_v, e_cnt})
      $display("FAIL redirect: addr=%h ins=%h pc4=%h v=%b cnt=%0d, want 40 %h %h %b %0d",
               addr[0], instr[0], pc4[0], valid[0], cnt[0], e_ins, e_p4, e_v, e_cnt);
    else passed++;
    set_in(1'b0, 1'b0, 1'b1, 32'h0000_0107);
    tick();
    checks++;
    if (addr[0] !== 32'h104) $display("FAIL redirect_align: addr=%h want 104", addr[0]);
    else passed++;
    redir = 1'b0;
    tick();
    checks++;
    if ({instr[0], pc4[0], valid[0]} !== {32'h1104, 32'h108, 1'b1})
      $display("FAIL after_redirect: ins=%h pc4=%h v=%b, want 1104 108 1", instr[0], pc4[0], valid[0]);
    else passed++;
    $display("test_redirect done");
  endtask

  task automatic test_stall_redirect();
    do_reset();
    run(2);
    set_in(1'b0, 1'b1, 1'b1, 32'h80);
    tick();
    checks++;
    if (addr[0] !== 32'h8) $display("FAIL stall_redirect_hold: addr=%h want 8", addr[0]);
    else passed++;
    stall = 1'b0;
    tick();
    checks++;
    if (addr[0] !== 32'h80) $display("FAIL stall_redirect_then: addr=%h want 80", addr[0]);
    else passed++;
    redir = 1'b0;
    $display("test_stall_redirect done");
  endtask

  task automatic test_wrap();
    do_reset();
    checks++;
    if (addr[1] !== 32'hFFFF_FFFC) $display("FAIL wrap_reset: addr=%h want fffffffc", addr[1]);
    else passed++;
    tick();
    checks++;
    if ({addr[1], instr[1], pc4[1], valid[1]} !== {32'h0, 32'h0FFC, 32'h0, 1'b1})
      $display("FAIL wrap_first: addr=%h ins=%h pc4=%h v=%b, want 0 ffc 0 1",
               addr[1], instr[1], pc4[1], valid[1]);
    else passed++;
    tick();
    checks++;
    if ({addr[1], pc4[1]} !== {32'h4, 32'h4})
      $display("FAIL wrap_second: addr=%h pc4=%h, want 4 4", addr[1], pc4[1]);
    else passed++;
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(12);
    set_in(1'b1, 1'b1, 1'b1, 32'h200);
    tick();
    checks++;
    if ({addr[0], instr[0], pc4[0], valid[0], cnt[0]} !== {RST_A, 32'h0, 32'h0, 1'b0, 32'h0})
      $display("FAIL reset_mid: addr=%h ins=%h pc4=%h v=%b cnt=%0d, want 0 0 0 0 0",
               addr[0], instr[0], pc4[0], valid[0], cnt[0]);
    else passed++;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({addr[k], instr[k], pc4[k], valid[k], cnt[k]} !==
            {m_pc[k], m_ins[k], m_p4[k], m_v[k], m_cnt[k]}) begin
          errs++;
          if (errs <= 10)
            $display("FAIL random[%0d] inst%0d: got addr=%h ins=%h pc4=%h v=%b cnt=%0d want addr=%h ins=%h pc4=%h v=%b cnt=%0d",
                     i, k, addr[k], instr[k], pc4[k], valid[k], cnt[k],
                     m_pc[k], m_ins[k], m_p4[k], m_v[k], m_cnt[k]);
        end else passed++;
      end
    end
    $display("test_random done, %0d cycles", 400);
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    test_reset();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
